data_mov_unit: RTL and testbench

Execution unit for the DATA function block. It runs while the control FSM sits in the DataMov state and raises ld_done when the operation completes, which lets the FSM advance to IncPC. It performs register move, load-immediate, memory load and memory store. Memory traffic uses a req/ack handshake with a timeout, and results go to the register file through a one-cycle write strobe.

---
 rtl/data_mov_unit.sv | 161 ++++++++++++++++
 tb/tb_data_mov_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mov_unit.sv
// DATA execution unit: register move, load-immediate, memory load and store.
// Memory traffic uses a req/ack handshake with an optional timeout.
module data_mov_unit #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [8:0]        state,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src_data,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] imm,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              ld_done,
  output logic              mem_err
);

  localparam logic [8:0] DATAMOV_ST = 9'b000010000;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, DONE} fsm_t;
  typedef enum logic [1:0] {OP_MOV = 2'b00, OP_LOAD = 2'b01, OP_STORE = 2'b10, OP_LOADI = 2'b11} op_t;

  fsm_t              fsm_q, fsm_d;
  op_t               op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              rf_we_q, rf_we_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              ld_done_q, ld_done_d;
  logic              mem_err_q, mem_err_d;

  logic              is_datamov;
  logic [CNT_W-1:0]  cnt_inc;

  assign is_datamov = (state == DATAMOV_ST);
  assign cnt_inc    = cnt_q + CNT_W'(1);

  always_comb begin
    fsm_d       = fsm_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rf_we_d     = 1'b0;
    rf_wdata_d  = rf_wdata_q;
    ld_done_d   = 1'b0;
    mem_err_d   = 1'b0;

    unique case (fsm_q)
      IDLE: begin
        if (is_datamov) begin
          op_d = op_t'(op);
          unique case (op_t'(op))
            OP_MOV, OP_LOADI: begin
              fsm_d      = DONE;
              ld_done_d  = 1'b1;
              rf_we_d    = 1'b1;
              rf_wdata_d = (op_t'(op) == OP_MOV) ? src_data : imm;
            end
            OP_LOAD, OP_STORE: begin
              fsm_d      = REQ;
              cnt_d      = '0;
              mem_req_d  = 1'b1;
              mem_we_d   = (op_t'(op) == OP_STORE);
              mem_addr_d = addr;
              if (op_t'(op) == OP_STORE) begin
                mem_wdata_d = src_data;
              end
            end
            default: fsm_d = IDLE;
          endcase
        end
      end

      REQ: begin
        // Leaving DataMov aborts silently; an ack beats a coincident timeout.
        if (!is_datamov) begin
          fsm_d     = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end else if (mem_ack) begin
          fsm_d     = DONE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          ld_done_d = 1'b1;
          if (op_q == OP_LOAD) begin
            rf_we_d    = 1'b1;
            rf_wdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_inc;
          if ((TIMEOUT != 0) && (cnt_inc == TIMEOUT_C)) begin
            fsm_d     = DONE;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
            ld_done_d = 1'b1;
            mem_err_d = 1'b1;
          end
        end
      end

      DONE: fsm_d = IDLE;

      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= IDLE;
      op_q        <= OP_MOV;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rf_we_q     <= 1'b0;
      rf_wdata_q  <= '0;
      ld_done_q   <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rf_we_q     <= rf_we_d;
      rf_wdata_q  <= rf_wdata_d;
      ld_done_q   <= ld_done_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rf_we     = rf_we_q;
  assign rf_wdata  = rf_wdata_q;
  assign ld_done   = ld_done_q;
  assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_data_mov_unit.sv
// Scoreboard bench for data_mov_unit: the driver pushes expected completions,
// a negedge monitor pops and compares them whenever ld_done is presented.
module tb_data_mov_unit;

  localparam logic [8:0] ST_FETCH   = 9'b000000001;
  localparam logic [8:0] ST_DATAMOV = 9'b000010000;
  localparam logic [8:0] ST_INCPC   = 9'b000100000;

  logic        clk;
  logic        rst;
  logic [8:0]  state;
  logic [1:0]  op;
  logic [15:0] src_data;
  logic [15:0] addr;
  logic [15:0] imm;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        rf_we;
  logic [15:0] rf_wdata;
  logic        ld_done;
  logic        mem_err;

  typedef struct {
    logic        we;
    logic [15:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  data_mov_unit #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .state     (state),
    .op        (op),
    .src_data  (src_data),
    .addr      (addr),
    .imm       (imm),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .rf_we     (rf_we),
    .rf_wdata  (rf_wdata),
    .ld_done   (ld_done),
    .mem_err   (mem_err)
  );

  // Free-running clock: rising edges at 5, 15, 25 ...; the bench works on falling edges.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle index used to pin down completion latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every ld_done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && ld_done === 1'b1) begin
      if (sbq.size() == 0) begin
        checkOutput("unexpected_ld_done", 32'(ld_done), 32'd0);
      end else begin
        cur = sbq.pop_front();
        checkOutput("done_cycle", 32'(cyc), 32'(cur.cyc));
        checkOutput("rf_we", 32'(rf_we), 32'(cur.we));
        checkOutput("mem_err", 32'(mem_err), 32'(cur.err));
        checkOutput("rf_wdata", 32'(rf_wdata), 32'(cur.data));
        checkOutput("mem_req_in_done", 32'(mem_req), 32'd0);
      end
    end
  end

  // One full DataMov operation. ackWait < 0 means memory never acknowledges.
  task automatic applyStimulus(input logic [1:0] o, input logic [15:0] s, input logic [15:0] a,
                               input logic [15:0] i, input logic [15:0] rd, input int ackWait,
                               input logic expWe, input logic [15:0] expData,
                               input logic expErr, input int expLat);
    exp_t e;
    bit   isMem;
    bit   seen;
    isMem = (o == 2'b01) || (o == 2'b10);
    seen  = 1'b0;
    @(negedge clk);
    state = ST_DATAMOV; op = o; src_data = s; addr = a; imm = i;
    e.we = expWe; e.data = expData; e.err = expErr; e.cyc = cyc + expLat;
    sbq.push_back(e);
    for (int w = 0; w < 40; w++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      src_data = ~s; addr = ~a; imm = ~i;
      if (ld_done) begin
        seen = 1'b1;
        break;
      end
      if (isMem) begin
        checkOutput("req_addr_we", {15'd0, mem_req, mem_we, mem_addr}, {15'd0, 1'b1, (o == 2'b10), a});
        if (o == 2'b10) checkOutput("mem_wdata", 32'(mem_wdata), 32'(s));
      end else begin
        checkOutput("mov_no_req", 32'(mem_req), 32'd0);
      end
      if (w == ackWait) begin
        mem_ack = 1'b1;
        mem_rdata = rd;
      end
    end
    if (!seen) checkOutput("ld_done_bound", 32'(seen), 32'd1);
    state = ST_INCPC;
    @(negedge clk);
    checkOutput("after_done", {28'd0, ld_done, rf_we, mem_err, mem_req}, 32'd0);
    state = ST_FETCH;
  endtask

  initial begin
    rst = 1'b1; state = ST_FETCH; op = 2'b00; src_data = '0; addr = '0; imm = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_ctrl", {27'd0, mem_req, mem_we, rf_we, ld_done, mem_err}, 32'd0);
    checkOutput("reset_data", {mem_addr, mem_wdata}, 32'd0);
    checkOutput("reset_rf_wdata", 32'(rf_wdata), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] MOV / LOADI");
    applyStimulus(2'b00, 16'h1234, 16'h0000, 16'h0000, 16'h0000, -1, 1'b1, 16'h1234, 1'b0, 1);
    applyStimulus(2'b11, 16'h0000, 16'h0000, 16'h00FF, 16'h0000, -1, 1'b1, 16'h00FF, 1'b0, 1);

    $display("[TB] LOAD with 3 wait cycles, STORE acked immediately");
    applyStimulus(2'b01, 16'h0000, 16'h0040, 16'h0000, 16'hBEEF, 3, 1'b1, 16'hBEEF, 1'b0, 5);
    applyStimulus(2'b10, 16'hA5A5, 16'h0100, 16'h0000, 16'h0000, 0, 1'b0, 16'hBEEF, 1'b0, 2);

    $display("[TB] timeout and ack on the timeout boundary");
    applyStimulus(2'b01, 16'h0000, 16'h0200, 16'h0000, 16'h0000, -1, 1'b0, 16'hBEEF, 1'b1, 16);
    applyStimulus(2'b01, 16'h0000, 16'h0300, 16'h0000, 16'h5A5A, 14, 1'b1, 16'h5A5A, 1'b0, 16);

    // Stray ack while idle must leave every output untouched.
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    checkOutput("stray_ack_ctrl", {28'd0, ld_done, rf_we, mem_err, mem_req}, 32'd0);
    checkOutput("stray_ack_data", 32'(rf_wdata), 32'h5A5A);

    // Non one-hot encoding containing the DataMov bit is not a start.
    state = 9'b000010001; op = 2'b00; src_data = 16'h7777;
    repeat (3) @(negedge clk);
    checkOutput("bad_onehot", {28'd0, ld_done, rf_we, mem_err, mem_req}, 32'd0);
    state = ST_FETCH;

    // Leaving DataMov during REQ aborts without completion.
    @(negedge clk);
    state = ST_DATAMOV; op = 2'b01; addr = 16'h0400;
    @(negedge clk);
    checkOutput("abort_req_up", 32'(mem_req), 32'd1);
    state = ST_INCPC;
    @(negedge clk);
    checkOutput("abort_req_down", {28'd0, ld_done, rf_we, mem_err, mem_req}, 32'd0);
    state = ST_FETCH;
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a REQ.
    state = ST_DATAMOV; op = 2'b01; addr = 16'h0500;
    repeat (2) @(negedge clk);
    checkOutput("pre_reset_req", 32'(mem_req), 32'd1);
    #2 rst = 1'b1; state = ST_FETCH;
    #1;
    checkOutput("async_reset", {28'd0, ld_done, rf_we, mem_err, mem_req}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'h2222;
    @(negedge clk);
    mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("late_ack_ignored", {28'd0, ld_done, rf_we, mem_err, mem_req}, 32'd0);
    checkOutput("reset_cleared_rf_wdata", 32'(rf_wdata), 32'd0);

    checkOutput("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
